// File: rtl/fpu_seq_pkg.sv
// Shared types for the FPU request sequencer: opcode bit positions,
// FSM states, latency classes and the class-to-latency map.
package fpu_seq_pkg;

  localparam int OP_FADD    = 0;
  localparam int OP_FSUB    = 1;
  localparam int OP_FMUL    = 2;
  localparam int OP_FDIV    = 3;
  localparam int OP_FSQRT   = 4;
  localparam int OP_FMIN    = 5;
  localparam int OP_FMAX    = 6;
  localparam int OP_FEQ     = 7;
  localparam int OP_FLT     = 8;
  localparam int OP_FLE     = 9;
  localparam int OP_FCVT_W  = 10;
  localparam int OP_FCVT_S  = 11;
  localparam int OP_FMADD   = 12;
  localparam int OP_FMSUB   = 13;
  localparam int OP_FCLASS  = 14;
  localparam int OP_FMV     = 15;
  localparam int OP_FNMADD  = 16;
  localparam int OP_FNMSUB  = 17;
  localparam int OP_FSGNJ   = 18;
  localparam int OP_FSGNJN  = 19;
  localparam int OP_FSGNJX  = 20;
  localparam int OP_FCVT_WU = 21;
  localparam int OP_FCVT_SU = 22;
  localparam int OP_SIGN    = 23;

  localparam logic [4:0] FLAG_NV = 5'b10000;
  localparam logic [4:0] FLAG_DZ = 5'b01000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE
  } state_e;

  typedef enum logic [1:0] {
    CLS_ONE,
    CLS_FMA,
    CLS_MUL,
    CLS_ILL
  } cls_e;

  function automatic int lat_sel(
    input cls_e c,
    input int   add_lat,
    input int   mul_lat
  );
    int l;
    unique case (c)
      CLS_FMA: l = add_lat;
      CLS_MUL: l = mul_lat;
      default: l = 1;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/fpu_resp_fifo.sv
// Show-ahead response FIFO with wrap-bit pointers; accepts a push while
// full as long as a pop happens in the same cycle.
module fpu_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         full;
  logic         pop_ok;
  logic         push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Head reads as zero when empty so stale entries never leak out.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fpu_seq_ctrl.sv
// FPU request sequencer: accepts one op at a time, issues it to the
// datapath, waits its class latency and queues the tagged result.
module fpu_seq_ctrl
  import fpu_seq_pkg::*;
#(
  parameter int STD     = 15,
  parameter int OPW     = 24,
  parameter int ADD_LAT = 3,
  parameter int MUL_LAT = 2,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 3
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OPW-1:0]   req_op,
  input  logic [2:0]       req_frm,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [STD:0]     req_a,
  input  logic [STD:0]     req_b,
  input  logic [STD:0]     req_c,
  input  logic [31:0]      req_int,
  output logic             dp_valid,
  output logic [OPW-1:0]   dp_op,
  output logic [2:0]       dp_frm,
  output logic [STD:0]     dp_a,
  output logic [STD:0]     dp_b,
  output logic [STD:0]     dp_c,
  output logic [31:0]      dp_int,
  input  logic [STD:0]     dp_result,
  input  logic [31:0]      dp_result_rd,
  input  logic [4:0]       dp_flags,
  input  logic             dp_exception,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [STD:0]     rsp_result,
  output logic [31:0]      rsp_result_rd,
  output logic [4:0]       rsp_flags,
  output logic [4:0]       fflags,
  input  logic             fflags_clr,
  input  logic             irq_en,
  output logic             irq,
  output logic             busy
);

  localparam int MAXL = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int CW   = $clog2(MAXL + 1);
  localparam int AW   = $clog2(DEPTH);
  localparam int DW   = TAG_W + STD + 1 + 32 + 5;

  state_e           state;
  state_e           state_n;
  cls_e             cls_q;
  cls_e             cls_d;
  logic [CW-1:0]    cnt;
  logic [TAG_W-1:0] tag_q;
  logic             accept;
  logic             onehot;
  logic             fma;
  logic             push;
  logic [STD:0]     push_res;
  logic [31:0]      push_rd;
  logic [4:0]       push_flags;
  logic [DW-1:0]    push_data;
  logic [DW-1:0]    head;
  logic [AW:0]      count;
  logic             empty;
  logic             irq_d;
  int               lat;

  assign req_ready = (state == S_IDLE) && (count < (AW+1)'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign dp_valid  = (state == S_ISSUE) && (cls_q != CLS_ILL);
  assign rsp_valid = !empty;
  assign busy      = (state != S_IDLE) || !empty;
  assign lat       = lat_sel(cls_q, ADD_LAT, MUL_LAT);

  always_comb begin
    onehot = (req_op != '0) &&
             ((req_op & (req_op - OPW'(1))) == '0);
    fma = req_op[OP_FADD]   | req_op[OP_FSUB]   |
          req_op[OP_FMADD]  | req_op[OP_FMSUB]  |
          req_op[OP_FNMADD] | req_op[OP_FNMSUB];
    cls_d = CLS_ONE;
    unique case (1'b1)
      !onehot || req_op[OP_FDIV] || req_op[OP_FSQRT]:
        cls_d = CLS_ILL;
      onehot && fma:
        cls_d = CLS_FMA;
      onehot && req_op[OP_FMUL]:
        cls_d = CLS_MUL;
      default:
        cls_d = CLS_ONE;
    endcase
  end

  always_comb begin
    state_n    = state;
    push       = 1'b0;
    push_res   = '0;
    push_rd    = '0;
    push_flags = '0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_n = S_ISSUE;
      end
      S_ISSUE: begin
        // Illegal ops never reach the datapath; answer with NV directly.
        if (cls_q == CLS_ILL) begin
          push       = 1'b1;
          push_flags = FLAG_NV;
          state_n    = S_IDLE;
        end else if (lat > 1) begin
          state_n = S_WAIT;
        end else begin
          state_n = S_CAPTURE;
        end
      end
      S_WAIT: begin
        if (cnt == CW'(1)) state_n = S_CAPTURE;
      end
      S_CAPTURE: begin
        push       = 1'b1;
        push_res   = dp_result;
        push_rd    = dp_result_rd;
        push_flags = dp_flags | (dp_exception ? FLAG_NV : 5'b0);
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign push_data = {tag_q, push_res, push_rd, push_flags};
  assign irq_d     = push && irq_en &&
                     (push_flags[4] || push_flags[3]);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state  <= S_IDLE;
      cls_q  <= CLS_ONE;
      cnt    <= '0;
      tag_q  <= '0;
      dp_op  <= '0;
      dp_frm <= '0;
      dp_a   <= '0;
      dp_b   <= '0;
      dp_c   <= '0;
      dp_int <= '0;
      fflags <= '0;
      irq    <= 1'b0;
    end else begin
      state <= state_n;
      irq   <= irq_d;
      if (accept) begin
        tag_q <= req_tag;
        cls_q <= cls_d;
        if (cls_d != CLS_ILL) begin
          dp_op  <= req_op;
          dp_frm <= req_frm;
          dp_a   <= req_a;
          dp_b   <= req_b;
          dp_c   <= req_c;
          dp_int <= req_int;
        end
      end
      if (state == S_ISSUE) begin
        cnt <= CW'(lat - 1);
      end else if (state == S_WAIT) begin
        cnt <= cnt - CW'(1);
      end
      if (push) begin
        fflags <= (fflags_clr ? 5'b0 : fflags) | push_flags;
      end else if (fflags_clr) begin
        fflags <= '0;
      end
    end
  end

  fpu_resp_fifo #(
    .DEPTH (DEPTH),
    .W     (DW)
  ) u_fifo (
    .clk   (clk),
    .rst_l (rst_l),
    .push  (push),
    .pop   (rsp_valid && rsp_ready),
    .din   (push_data),
    .dout  (head),
    .count (count),
    .empty (empty)
  );

  assign {rsp_tag, rsp_result, rsp_result_rd, rsp_flags} = head;

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Directed bench for fpu_seq_ctrl with a latency-accurate datapath stub
// and a tagged response scoreboard.
module tb_fpu_seq_ctrl;

  localparam int ADD_LAT = 3;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_op = '0;
  logic [2:0]  req_frm = '0;
  logic [2:0]  req_tag = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [15:0] req_c = '0;
  logic [31:0] req_int = '0;
  logic        dp_valid;
  logic [23:0] dp_op;
  logic [2:0]  dp_frm;
  logic [15:0] dp_a, dp_b, dp_c;
  logic [31:0] dp_int;
  logic [15:0] dp_result;
  logic [31:0] dp_result_rd;
  logic [4:0]  dp_flags;
  logic        dp_exception;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [2:0]  rsp_tag;
  logic [15:0] rsp_result;
  logic [31:0] rsp_result_rd;
  logic [4:0]  rsp_flags;
  logic [4:0]  fflags;
  logic        fflags_clr = 1'b0;
  logic        irq_en = 1'b1;
  logic        irq;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int dv_cnt = 0;
  int dv0;

  typedef struct {
    logic [2:0]  tag;
    logic [15:0] res;
    logic [31:0] rd;
    logic [4:0]  fl;
  } exp_t;
  exp_t q[$];

  logic [15:0] stub_val = '0;
  logic [31:0] stub_rd = '0;
  logic [4:0]  stub_flags = '0;
  logic        stub_exc = 1'b0;
  int          k = 0;
  int          stub_lat;

  always #5 clk = ~clk;

  fpu_seq_ctrl dut (
    .clk(clk), .rst_l(rst_l),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_frm(req_frm), .req_tag(req_tag),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_int(req_int),
    .dp_valid(dp_valid), .dp_op(dp_op), .dp_frm(dp_frm),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_int(dp_int),
    .dp_result(dp_result), .dp_result_rd(dp_result_rd),
    .dp_flags(dp_flags), .dp_exception(dp_exception),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_tag(rsp_tag), .rsp_result(rsp_result),
    .rsp_result_rd(rsp_result_rd), .rsp_flags(rsp_flags),
    .fflags(fflags), .fflags_clr(fflags_clr),
    .irq_en(irq_en), .irq(irq), .busy(busy)
  );

  // Stub presents valid data only on the edge where the datapath must be sampled.
  always_comb begin
    stub_lat = 1;
    if (dp_op[2]) stub_lat = MUL_LAT;
    if (dp_op[0] | dp_op[1] | dp_op[12] | dp_op[13] | dp_op[16] | dp_op[17])
      stub_lat = ADD_LAT;
  end
  assign dp_result    = (k == stub_lat) ? stub_val : 16'hDEAD;
  assign dp_result_rd = (k == stub_lat) ? stub_rd : 32'hDEADBEEF;
  assign dp_flags     = (k == stub_lat) ? stub_flags : 5'b11111;
  assign dp_exception = (k == stub_lat) ? stub_exc : 1'b0;

  always @(posedge clk) begin
    if (dp_valid) begin
      k <= 1;
      dv_cnt <= dv_cnt + 1;
    end else if (k != 0 && k < 200) begin
      k <= k + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] obs,
                     input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", nm, obs, exp_v);
    end
  endtask

  task automatic exp_push(input logic [2:0] t, input logic [15:0] r,
                          input logic [31:0] d, input logic [4:0] f);
    exp_t e;
    e.tag = t; e.res = r; e.rd = d; e.fl = f;
    q.push_back(e);
  endtask

  task automatic send(input logic [23:0] op, input logic [2:0] t,
                      input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_tag = t;
    req_a = a; req_b = b; req_c = 16'h1234; req_int = 32'h55;
    req_frm = 3'd1;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++; failures++;
      $error("FAIL send_timeout obs=%0b exp=1", req_ready);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(input string nm);
    exp_t e;
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_valid"}, 64'(rsp_valid), 64'd1);
    if (rsp_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $error("FAIL %s_sb obs=response exp=none", nm);
      end else begin
        e = q.pop_front();
        chk({nm, "_tag"}, 64'(rsp_tag), 64'(e.tag));
        chk({nm, "_res"}, 64'(rsp_result), 64'(e.res));
        chk({nm, "_rd"}, 64'(rsp_result_rd), 64'(e.rd));
        chk({nm, "_flags"}, 64'(rsp_flags), 64'(e.fl));
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  task automatic clear_flags();
    @(negedge clk);
    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_dp_valid", 64'(dp_valid), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    chk("rst_dp_op", 64'(dp_op), 64'd0);
    chk("rst_fflags", 64'(fflags), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_l = 1'b1;

    // Fadd: response exactly ADD_LAT+1 edges after the accept edge
    stub_val = 16'h4200; stub_rd = 32'h0; stub_flags = 5'b0;
    exp_push(3'd5, 16'h4200, 32'h0, 5'b0);
    send(24'h1 << 0, 3'd5, 16'h3C00, 16'h4000);
    chk("fadd_dp_valid", 64'(dp_valid), 64'd1);
    chk("fadd_dp_a", 64'(dp_a), 64'h3C00);
    repeat (ADD_LAT) @(posedge clk);
    #1 chk("fadd_early", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1 chk("fadd_on_time", 64'(rsp_valid), 64'd1);
    wait_rsp("fadd");
    chk("fadd_fflags", 64'(fflags), 64'd0);

    // Illegal div: NV response, no issue, irq gated by irq_en
    dv0 = dv_cnt;
    exp_push(3'd2, 16'h0, 32'h0, 5'b10000);
    send(24'h1 << 3, 3'd2, 16'h1, 16'h2);
    chk("div_no_issue", 64'(dp_valid), 64'd0);
    chk("div_early", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("div_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("div_irq", 64'(irq), 64'd1);
    chk("div_fflags", 64'(fflags), 64'h10);
    chk("div_dp_op_hold", 64'(dp_op), 64'h1);
    @(posedge clk);
    #1 chk("div_irq_pulse", 64'(irq), 64'd0);
    wait_rsp("div");
    clear_flags();
    chk("clr_fflags", 64'(fflags), 64'd0);
    irq_en = 1'b0;
    exp_push(3'd3, 16'h0, 32'h0, 5'b10000);
    send(24'h1 << 4, 3'd3, 16'h1, 16'h2);
    @(posedge clk);
    #1 chk("sqrt_irq_off", 64'(irq), 64'd0);
    wait_rsp("sqrt");
    chk("ill_no_dp_valid", 64'(dv_cnt), 64'(dv0));
    irq_en = 1'b1;
    clear_flags();

    // Fill the FIFO with four Fmul results
    for (int i = 0; i < 4; i++) begin
      stub_val = 16'h1000 + 16'(i);
      exp_push(3'(i), 16'h1000 + 16'(i), 32'h0, 5'b0);
      send(24'h1 << 2, 3'(i), 16'h1, 16'h2);
      repeat (MUL_LAT + 1) @(posedge clk);
      #1;
    end
    chk("full_req_ready", 64'(req_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 chk("full_hold", 64'(req_ready), 64'd0);
    @(negedge clk);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e = q.pop_front();
      chk("full_tag", 64'(rsp_tag), 64'(e.tag));
      chk("full_res", 64'(rsp_result), 64'(e.res));
      @(posedge clk);
      #1;
      if (i == 0) chk("full_ready_back", 64'(req_ready), 64'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    chk("full_drained", 64'(rsp_valid), 64'd0);

    // Sticky flag accumulation and clear-with-push
    stub_flags = 5'b00001;
    exp_push(3'd1, 16'h1000 + 16'd3, 32'h0, 5'b00001);
    send(24'h1 << 0, 3'd1, 16'h1, 16'h2);
    wait_rsp("nx");
    stub_flags = 5'b00101;
    exp_push(3'd2, 16'h1000 + 16'd3, 32'h0, 5'b00101);
    send(24'h1 << 2, 3'd2, 16'h1, 16'h2);
    wait_rsp("ofnx");
    chk("acc_fflags", 64'(fflags), 64'h05);
    stub_flags = 5'b01000;
    exp_push(3'd3, 16'h1000 + 16'd3, 32'h0, 5'b01000);
    send(24'h1 << 2, 3'd3, 16'h1, 16'h2);
    repeat (MUL_LAT) @(posedge clk);
    #1 fflags_clr = 1'b1;
    @(posedge clk);
    #1 fflags_clr = 1'b0;
    chk("clr_push_fflags", 64'(fflags), 64'h08);
    chk("dz_irq", 64'(irq), 64'd1);
    wait_rsp("dz");

    // Datapath exception forces NV
    clear_flags();
    stub_flags = 5'b0; stub_exc = 1'b1; stub_val = 16'h7E00;
    exp_push(3'd6, 16'h7E00, 32'h0, 5'b10000);
    send(24'h1 << 12, 3'd6, 16'h1, 16'h2);
    wait_rsp("exc");
    stub_exc = 1'b0;
    chk("exc_fflags", 64'(fflags), 64'h10);
    clear_flags();

    // Async reset mid-WAIT with two entries queued
    stub_flags = 5'b00001;
    for (int i = 0; i < 2; i++) begin
      send(24'h1 << 2, 3'(i + 1), 16'h1, 16'h2);
      repeat (MUL_LAT + 1) @(posedge clk);
      #1;
    end
    chk("pre_rst_fflags", 64'(fflags), 64'h01);
    send(24'h1 << 0, 3'd3, 16'h1, 16'h2);
    @(posedge clk);
    #2 rst_l = 1'b0;
    #1;
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_fflags", 64'(fflags), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_l = 1'b1;
    stub_flags = 5'b0; stub_val = 16'h4400; stub_rd = 32'hA5;
    exp_push(3'd6, 16'h4400, 32'hA5, 5'b0);
    send(24'h1 << 0, 3'd6, 16'h1, 16'h2);
    wait_rsp("post_rst");

    // Multi-hot opcode is illegal
    exp_push(3'd4, 16'h0, 32'h0, 5'b10000);
    send(24'h3, 3'd4, 16'h1, 16'h2);
    wait_rsp("multihot");
    chk("sb_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
